unidad_busqueda: RTL

UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

---
 rtl/unidad_busqueda.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: requests words from instruction memory and hands them to decode.
// Optional macro ALINEACION_CHK_EN traps misaligned redirect targets in a sticky ERROR state.
module unidad_busqueda #(
  parameter int              Bits      = 64,
  parameter logic [Bits-1:0] PCInicial = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            MemReq,
  output logic [Bits-1:0] MemAddr,
  input  logic            MemAck,
  input  logic [31:0]     MemData,
  input  logic            Salto,
  input  logic [Bits-1:0] DestinoSalto,
  output logic [31:0]     Instruccion,
  output logic [Bits-1:0] PCInstr,
  output logic            Valido,
  input  logic            Listo,
  output logic            ErrorAlineacion
);

  // states: INACTIVO one-cycle idle | PEDIR request at pc | DESCARTAR drop stale response
  //         ENTREGAR hold word for decode | ERROR misaligned target trap (macro only)
`ifdef ALINEACION_CHK_EN
  typedef enum logic [2:0] {INACTIVO, PEDIR, DESCARTAR, ENTREGAR, ERROR} estado_t;
`else
  typedef enum logic [2:0] {INACTIVO, PEDIR, DESCARTAR, ENTREGAR} estado_t;
`endif

  localparam logic [Bits-1:0] Cuatro = {{(Bits-3){1'b0}}, 3'd4};
  localparam logic [Bits-1:0] Mascara = ~{{(Bits-2){1'b0}}, 2'b11};

  estado_t         estado, estado_next;
  logic [Bits-1:0] pc, pc_next;
  logic [Bits-1:0] mem_addr_q, addr_next;
  logic [Bits-1:0] destino;
  logic [31:0]     instr;
  logic [Bits-1:0] pc_instr;
  logic            capturar;
  logic            req;
  logic            valido;
  logic            salto_act;
  logic            salto_mal;

`ifdef ALINEACION_CHK_EN
  logic err, err_next;
  assign destino   = DestinoSalto;
  assign salto_act = Salto && (estado != ERROR);
  assign salto_mal = |DestinoSalto[1:0];
`else
  assign destino   = DestinoSalto & Mascara;
  assign salto_act = Salto;
  assign salto_mal = 1'b0;
`endif

  always_comb begin
    estado_next = estado;
    pc_next     = pc;
    addr_next   = mem_addr_q;
    capturar    = 1'b0;
    req         = 1'b0;
    valido      = 1'b0;
`ifdef ALINEACION_CHK_EN
    err_next    = err;
`endif
    case (estado)
      INACTIVO: estado_next = PEDIR;
      PEDIR: begin
        req = 1'b1;
        if (MemAck) begin
          capturar    = 1'b1;
          estado_next = ENTREGAR;
        end
      end
      DESCARTAR: begin
        req = 1'b1;
        if (MemAck) estado_next = PEDIR;
      end
      ENTREGAR: begin
        valido = 1'b1;
        if (Listo) begin
          pc_next     = pc + Cuatro;
          estado_next = PEDIR;
        end
      end
      default: ;
    endcase

    // A redirect overrides everything; an outstanding request must still be drained.
    if (salto_act) begin
      valido   = 1'b0;
      capturar = 1'b0;
      pc_next  = destino;
      if (estado == PEDIR || estado == DESCARTAR)
        estado_next = MemAck ? PEDIR : DESCARTAR;
      else
        estado_next = PEDIR;
`ifdef ALINEACION_CHK_EN
      if (salto_mal) begin
        estado_next = ERROR;
        err_next    = 1'b1;
      end
`endif
    end

    if (estado_next == PEDIR) addr_next = pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= INACTIVO;
      pc         <= PCInicial;
      mem_addr_q <= PCInicial;
      instr      <= '0;
      pc_instr   <= '0;
    end else begin
      estado     <= estado_next;
      pc         <= pc_next;
      mem_addr_q <= addr_next;
      if (capturar) begin
        instr    <= MemData;
        pc_instr <= pc;
      end
    end
  end

`ifdef ALINEACION_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= err_next;
  end
  assign ErrorAlineacion = err;
`else
  assign ErrorAlineacion = 1'b0;
`endif

  assign MemReq      = req;
  assign MemAddr     = mem_addr_q;
  assign Valido      = valido;
  assign Instruccion = instr;
  assign PCInstr     = pc_instr;

  logic unused_ok;
  assign unused_ok = salto_mal;

endmodule
